// File: rtl/vtg_pattern.sv
// Video timing generator with built-in YUV 4:2:2 test patterns.
// Produces pvsync / pvde / pdata for a downstream pixel pipeline. Frame
// geometry and pattern select are captured when VSYNC is entered and held
// for the whole frame. All outputs come straight from flops.
module vtg_pattern #(
  parameter int VSYNC_W = 4
) (
  input  logic        pclk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [10:0] frm_width,
  input  logic [10:0] frm_height,
  input  logic [7:0]  hblank,
  input  logic [5:0]  vblank,
  input  logic [1:0]  pat_sel,
  output logic        pvde,
  output logic [15:0] pdata,
  output logic        pvsync
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBLANK = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4
  } state_t;

  localparam logic [11:0] LP_VSW_M1 = 12'(VSYNC_W - 1);

  // Pixel value for the selected pattern at position (x, y).
  // Chroma alternates U (even x) / V (odd x).
  function automatic logic [15:0] f_pixel(
    input logic [1:0]  pat,
    input logic [10:0] x,
    input logic [10:0] y,
    input logic        fodd
  );
    logic [7:0] y_byte;
    logic [7:0] c_byte;
    begin
      case (pat)
        2'd0: begin
          y_byte = 8'h80;
          c_byte = 8'h80;
        end
        2'd1: begin
          y_byte = x[7:0];
          c_byte = x[0] ? 8'hA0 : 8'h60;
        end
        2'd2: begin
          y_byte = y[7:0];
          c_byte = 8'h80;
        end
        2'd3: begin
          y_byte = (x[3] ^ y[3] ^ fodd) ? 8'hEB : 8'h10;
          c_byte = 8'h80;
        end
        default: begin
          y_byte = 8'h00;
          c_byte = 8'h00;
        end
      endcase
      f_pixel = {y_byte, c_byte};
    end
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_cnt;
  logic [11:0] w_cnt_nxt;
  logic [10:0] r_x;
  logic [10:0] w_x_nxt;
  logic [10:0] r_y;
  logic [10:0] w_y_nxt;
  logic [5:0]  r_vline;
  logic [5:0]  w_vline_nxt;
  logic        r_fodd;

  // Per-frame copies of the geometry / pattern inputs
  logic [10:0] r_frm_w;
  logic [10:0] r_frm_h;
  logic [7:0]  r_hb;
  logic [5:0]  r_vb;
  logic [1:0]  r_pat;

  logic        r_pvde;
  logic [15:0] r_pdata;
  logic        r_pvsync;

  logic [11:0] w_line_m1;
  logic        w_enter_vs;

  // Blanking line period minus one: (w+1)+(hb+1)-1
  assign w_line_m1  = {1'b0, r_frm_w} + {4'b0000, r_hb} + 12'd1;
  assign w_enter_vs = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);

  // Next-state and counter update logic for the frame sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vline_nxt = r_vline;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_VSYNC;
          w_cnt_nxt   = 12'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_VSYNC: begin
        if (r_cnt == LP_VSW_M1) begin
          w_state_nxt = S_VBLANK;
          w_cnt_nxt   = 12'd0;
          w_vline_nxt = 6'd0;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_VBLANK: begin
        if (r_cnt == w_line_m1) begin
          w_cnt_nxt = 12'd0;
          if (r_vline == r_vb) begin
            w_state_nxt = S_ACTIVE;
            w_x_nxt     = 11'd0;
            w_y_nxt     = 11'd0;
          end else begin
            w_vline_nxt = r_vline + 6'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_ACTIVE: begin
        if (r_x == r_frm_w) begin
          w_state_nxt = S_HBLANK;
          w_cnt_nxt   = 12'd0;
        end else begin
          w_x_nxt = r_x + 11'd1;
        end
      end
      S_HBLANK: begin
        if (r_cnt == {4'b0000, r_hb}) begin
          w_cnt_nxt = 12'd0;
          if (r_y == r_frm_h) begin
            // Frame done: enable only matters here, never mid-frame
            if (enable) begin
              w_state_nxt = S_VSYNC;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_ACTIVE;
            w_x_nxt     = 11'd0;
            w_y_nxt     = r_y + 11'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 12'd0;
        w_x_nxt     = 11'd0;
        w_y_nxt     = 11'd0;
        w_vline_nxt = 6'd0;
      end
    endcase
  end

  // Sequencer state and position counters
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 12'd0;
      r_x     <= 11'd0;
      r_y     <= 11'd0;
      r_vline <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vline <= w_vline_nxt;
    end
  end

  // Capture frame parameters and flip frame parity on every VSYNC entry
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_frm_w <= 11'd0;
      r_frm_h <= 11'd0;
      r_hb    <= 8'd0;
      r_vb    <= 6'd0;
      r_pat   <= 2'd0;
      r_fodd  <= 1'b0;
    end else if (w_enter_vs) begin
      r_frm_w <= frm_width;
      r_frm_h <= frm_height;
      r_hb    <= hblank;
      r_vb    <= vblank;
      r_pat   <= pat_sel;
      r_fodd  <= ~r_fodd;
    end else begin
      r_fodd  <= r_fodd;
    end
  end

  // Output flops, decoded from the next state so they align with the state
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_pvsync <= 1'b0;
      r_pvde   <= 1'b0;
      r_pdata  <= 16'h0000;
    end else begin
      r_pvsync <= (w_state_nxt == S_VSYNC);
      r_pvde   <= (w_state_nxt == S_ACTIVE);
      if (w_state_nxt == S_ACTIVE) begin
        r_pdata <= f_pixel(r_pat, w_x_nxt, w_y_nxt, r_fodd);
      end else begin
        r_pdata <= 16'h0000;
      end
    end
  end

  assign pvsync = r_pvsync;
  assign pvde   = r_pvde;
  assign pdata  = r_pdata;

endmodule

// File: tb/tb_vtg_pattern.sv
// Directed bench for vtg_pattern: frame timing, patterns, enable drop,
// mid-frame parameter change and asynchronous reset during ACTIVE.
module tb_vtg_pattern;

  logic        pclk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [10:0] frm_width;
  logic [10:0] frm_height;
  logic [7:0]  hblank;
  logic [5:0]  vblank;
  logic [1:0]  pat_sel;
  logic        pvde;
  logic [15:0] pdata;
  logic        pvsync;

  int errors = 0;
  int checks = 0;
  int t      = 0;

  always #5 pclk = ~pclk;

  vtg_pattern #(.VSYNC_W(4)) dut (
    .pclk       (pclk),
    .rstn       (rstn),
    .enable     (enable),
    .frm_width  (frm_width),
    .frm_height (frm_height),
    .hblank     (hblank),
    .vblank     (vblank),
    .pat_sel    (pat_sel),
    .pvde       (pvde),
    .pdata      (pdata),
    .pvsync     (pvsync)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    t++;
  endtask

  task automatic adv(input int n);
    while (t < n) step();
  endtask

  // Wait (bounded) for pvsync to go high; that cycle becomes t=0
  task automatic wait_rise();
    int k;
    k = 0;
    while (pvsync !== 1'b1 && k < 400) begin
      @(negedge pclk);
      k++;
    end
    check("vs_rise", {31'd0, pvsync}, 32'd1);
    t = 0;
  endtask

  initial begin
    logic        e_vs;
    logic        e_de;
    logic [15:0] e_pd;
    int          k;

    rstn       = 1'b0;
    enable     = 1'b0;
    frm_width  = 11'd7;
    frm_height = 11'd3;
    hblank     = 8'd3;
    vblank     = 6'd1;
    pat_sel    = 2'd1;
    repeat (2) @(negedge pclk);
    check("rst_pvde",   {31'd0, pvde},   32'd0);
    check("rst_pvsync", {31'd0, pvsync}, 32'd0);
    check("rst_pdata",  {16'd0, pdata},  32'd0);

    // Out of reset with enable low: stays idle
    rstn = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check("idle_vs", {31'd0, pvsync}, 32'd0);
      check("idle_de", {31'd0, pvde},   32'd0);
    end

    // Frame 1/2: w=7 h=3 hb=3 vb=1, h-ramp
    enable = 1'b1;
    wait_rise();
    while (t <= 76) begin
      k    = t - 28;
      e_vs = (t < 4) || (t == 76);
      e_de = (t >= 28) && (t < 76) && ((k % 12) < 8);
      e_pd = 16'h0000;
      if (e_de) begin
        k    = k % 12;
        e_pd = {k[7:0], (k[0] ? 8'hA0 : 8'h60)};
      end
      check("f1_vs", {31'd0, pvsync}, {31'd0, e_vs});
      check("f1_de", {31'd0, pvde},   {31'd0, e_de});
      check("f1_pd", {16'd0, pdata},  {16'd0, e_pd});
      step();
    end
    adv(80);
    frm_width = 11'd15;
    pat_sel   = 2'd3;

    // Frame 3: checker, odd frame parity
    wait_rise();
    while (t < 64) begin
      e_vs = (t < 4);
      e_de = (t >= 44) && (t < 60);
      e_pd = e_de ? {(((t - 44) < 8) ? 8'hEB : 8'h10), 8'h80} : 16'h0000;
      check("f3_vs", {31'd0, pvsync}, {31'd0, e_vs});
      check("f3_de", {31'd0, pvde},   {31'd0, e_de});
      check("f3_pd", {16'd0, pdata},  {16'd0, e_pd});
      step();
    end

    // Frame 4: checker inverted
    wait_rise();
    while (t < 64) begin
      e_de = (t >= 44) && (t < 60);
      e_pd = e_de ? {(((t - 44) < 8) ? 8'h10 : 8'hEB), 8'h80} : 16'h0000;
      check("f4_de", {31'd0, pvde},  {31'd0, e_de});
      check("f4_pd", {16'd0, pdata}, {16'd0, e_pd});
      step();
    end
    frm_width = 11'd7;
    pat_sel   = 2'd2;

    // Frame 5: v-ramp, width changed mid-frame (no effect until next frame)
    wait_rise();
    while (t <= 76) begin
      k    = t - 28;
      e_vs = (t < 4) || (t == 76);
      e_de = (t >= 28) && (t < 76) && ((k % 12) < 8);
      e_pd = 16'h0000;
      if (e_de) begin
        k    = k / 12;
        e_pd = {k[7:0], 8'h80};
      end
      check("f5_vs", {31'd0, pvsync}, {31'd0, e_vs});
      check("f5_de", {31'd0, pvde},   {31'd0, e_de});
      check("f5_pd", {16'd0, pdata},  {16'd0, e_pd});
      if (t == 30) begin
        frm_width = 11'd3;
        pat_sel   = 2'd0;
      end
      step();
    end

    // Frame 6: 4-pixel lines, flat; enable dropped during line 1
    t = t - 76;
    while (t <= 60) begin
      if (t == 29) enable = 1'b0;
      e_vs = (t < 4);
      e_de = (t >= 20) && (t < 52) && (((t - 20) % 8) < 4);
      e_pd = e_de ? 16'h8080 : 16'h0000;
      check("f6_vs", {31'd0, pvsync}, {31'd0, e_vs});
      check("f6_de", {31'd0, pvde},   {31'd0, e_de});
      check("f6_pd", {16'd0, pdata},  {16'd0, e_pd});
      if (t == 60) enable = 1'b1;
      step();
    end
    check("reen_vs", {31'd0, pvsync}, 32'd1);

    // Frame 7: reset pulled during ACTIVE
    t = 0;
    adv(21);
    check("pre_rst_de", {31'd0, pvde}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("arst_pvde",   {31'd0, pvde},   32'd0);
    check("arst_pvsync", {31'd0, pvsync}, 32'd0);
    check("arst_pdata",  {16'd0, pdata},  32'd0);
    frm_width = 11'd15;
    pat_sel   = 2'd3;
    @(negedge pclk);
    rstn = 1'b1;

    // Frame 8: fresh start, full VSYNC and odd parity again
    wait_rise();
    while (t < 56) begin
      e_vs = (t < 4);
      e_de = (t >= 44) && (t < 60);
      e_pd = e_de ? {(((t - 44) < 8) ? 8'hEB : 8'h10), 8'h80} : 16'h0000;
      check("f8_vs", {31'd0, pvsync}, {31'd0, e_vs});
      check("f8_de", {31'd0, pvde},   {31'd0, e_de});
      check("f8_pd", {16'd0, pdata},  {16'd0, e_pd});
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vtg_pattern.md
VTG_PATTERN -- requirements
Module: vtg_pattern

Interface
REQ-001 The block SHALL have this parameter: VSYNC_W, default 4, pvsync pulse width in pclk cycles (legal 1..15).
REQ-002 The block SHALL have this port: pclk  in  1  pixel clock; all logic on rising edge.
REQ-003 The block SHALL have this port: rstn  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have this port: enable  in  1  1'b1 = generate frames; sampled only at frame boundaries.
REQ-005 The block SHALL have this port: frm_width  in  11  active pixels per line minus 1 (count from 0).
REQ-006 The block SHALL have this port: frm_height  in  11  active lines per frame minus 1 (count from 0).
REQ-007 The block SHALL have this port: hblank  in  8  horizontal blanking cycles minus 1.
REQ-008 The block SHALL have this port: vblank  in  6  vertical blanking line periods minus 1.
REQ-009 The block SHALL have this port: pat_sel  in  2  test pattern select.
REQ-010 The block SHALL have this port: pvde  out  1  1'b1 = valid pixel in a line; feeds the gauss filter's pvde.
REQ-011 The block SHALL have this port: pdata  out  16  {Y,U} on even pixels, {Y,V} on odd pixels; feeds pdata.
REQ-012 The block SHALL have this port: pvsync  out  1  frame sync, high pulse; feeds pvsync.

Function
REQ-013 The block SHALL register all outputs (no combinational path from any input to any output).
REQ-014 The block SHALL implement the states IDLE, VSYNC, VBLANK, ACTIVE and HBLANK.
REQ-015 IDLE SHALL go to VSYNC on the first cycle enable=1.
REQ-016 VSYNC SHALL last VSYNC_W cycles and then go to VBLANK.
REQ-017 VBLANK SHALL last (vblank+1) line periods and then go to ACTIVE.
REQ-018 ACTIVE SHALL last (frm_width+1) cycles and then go to HBLANK.
REQ-019 HBLANK SHALL last (hblank+1) cycles, then go to ACTIVE if lines remain; after the last line it SHALL go to VSYNC if enable=1, else to IDLE.
REQ-020 One line period SHALL be (frm_width+1)+(hblank+1) cycles; a frame SHALL have (frm_height+1) active lines.
REQ-021 frm_width, frm_height, hblank, vblank and pat_sel SHALL be latched on the cycle VSYNC is entered and held constant for the whole frame; changes mid-frame SHALL have no effect until the next frame.
REQ-022 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-023 pvsync SHALL be 1 exactly during VSYNC cycles and 0 otherwise.
REQ-024 pvde SHALL be 1 exactly during ACTIVE cycles.
REQ-025 pdata SHALL be 16'h0000 whenever pvde=0.
REQ-026 Pixel counter x (11 bit) and line counter y (11 bit) SHALL reset to 0 at the start of each line and each frame respectively.
REQ-027 Chroma byte C SHALL be U when x[0]=0 and V when x[0]=1.
REQ-028 pat_sel=0 (flat) SHALL output Y=8'h80, U=V=8'h80.
REQ-029 pat_sel=1 (h-ramp) SHALL output Y=x[7:0] (wraps every 256 pixels), U=8'h60, V=8'hA0.
REQ-030 pat_sel=2 (v-ramp) SHALL output Y=y[7:0], U=V=8'h80.
REQ-031 pat_sel=3 (checker) SHALL output Y=8'hEB when (x[3]^y[3]^fodd)=1, else 8'h10; U=V=8'h80.
REQ-032 fodd SHALL be a frame-parity bit that toggles on every VSYNC entry and is cleared by reset.
REQ-033 The frame with fodd=1 SHALL be the first frame after reset.
REQ-034 Minimum values (all size inputs = 0) SHALL be legal: 1 pixel, 1 blank cycle, 1 line, 1 blank line.

Reset
REQ-035 While rstn=0: state SHALL be IDLE, x, y and fodd SHALL be 0, and pvde=0, pvsync=0, pdata=16'h0000.
REQ-036 Reset asserted mid-frame SHALL force all outputs to 0 asynchronously.
REQ-037 After reset release, generation SHALL restart with a full VSYNC only once enable=1.

Verification
REQ-038 Frame timing: VSYNC_W=4, frm_width=7, frm_height=3, hblank=3, vblank=1, enable held 1 -> pvsync high 4 cycles, then 24 blank cycles, then 4 lines each of 8 pvde=1 cycles + 4 pvde=0 cycles; next pvsync rises 76 cycles after the previous rise.
REQ-039 Pattern 1, frm_width=7 -> pdata on line 0 = 16'h0060, 16'h01A0, 16'h0260, ..., 16'h07A0.
REQ-040 Pattern 3, frm_width=15 -> first frame line 0: pixels 0-7 Y=8'hEB, pixels 8-15 Y=8'h10; second frame inverted.
REQ-041 Enable drop: deassert enable during line 1 -> frame completes all 4 lines, then pvsync stays 0 and the block sits in IDLE; reassert -> a new VSYNC occurs on the next cycle.
REQ-042 Mid-frame change: change frm_width from 7 to 3 during ACTIVE -> current frame keeps 8-pixel lines, next frame has 4-pixel lines.
REQ-043 Reset during ACTIVE: pull rstn low -> pvde, pvsync and pdata are 0 immediately; after release with enable=1 -> first pvsync pulse is 4 cycles long and the checker uses fodd=1.
